dma_mem_arbiter: RTL

- Shares the single-port 64 KB block RAM between the 6502C core and one read-only DMA requester, such as an ANTIC-style display-list and playfield fetcher.
- Sits between top_6502C and blkMem on the memory clock.
- Steals bus slots for DMA by pulling the CPU RDY line low, only on CPU read cycles, because the 6502 ignores RDY on writes.
- Enforces a DMA burst cap so the CPU is never starved.

---
 rtl/dma_mem_arbiter_pkg.sv | 19 +
 rtl/dma_mem_arbiter_if.sv | 30 +++
 rtl/dma_mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dma_mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA block-RAM arbiter: state encoding,
// RAM timing and the burst counter helper.
package arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CPU_ADR = 3'd1,
        S_CPU_DAT = 3'd2,
        S_DMA_ADR = 3'd3,
        S_DMA_DAT = 3'd4
    } state_e;

    localparam int RAM_LATENCY = 1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dma_mem_arbiter_if.sv
// Bus bundle between the 6502 core, the DMA requester, the RAM and the arbiter.
interface dma_mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              cpu_cyc;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rw;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_done;
    logic              rdy;
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_rdata;
    logic              dma_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;

    modport slave (
        input  cpu_cyc, cpu_addr, cpu_rw, cpu_wdata, dma_req, dma_addr, mem_dout,
        output cpu_rdata, cpu_done, rdy, dma_rdata, dma_ack, mem_addr, mem_we, mem_din
    );

    modport master (
        output cpu_cyc, cpu_addr, cpu_rw, cpu_wdata, dma_req, dma_addr, mem_dout,
        input  cpu_rdata, cpu_done, rdy, dma_rdata, dma_ack, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Single-port RAM arbiter: 6502 accesses plus read-only DMA, stealing slots by
// holding RDY low on CPU reads, with a burst cap that guarantees CPU progress.
module dma_mem_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_DMA_BURST = 8,
    parameter int ADDR_W        = 16
) (
    input logic              clk,
    input logic              rst_L,
    dma_mem_arbiter_if.slave bus
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_DMA_BURST);

    state_e            state_q, state_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic              lat_rw_q, lat_rw_d;
    logic [7:0]        lat_wdata_q, lat_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        dma_rdata_q, dma_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              dma_ack_q, dma_ack_d;
    logic              rdy_q, rdy_d;

    logic              arb_en;
    logic              pend_eff;
    logic [7:0]        burst_eff;
    logic              cyc_eff;

    always_comb begin
        state_d     = state_q;
        cpu_pend_d  = cpu_pend_q;
        burst_cnt_d = burst_cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_rw_d    = lat_rw_q;
        lat_wdata_d = lat_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_din_d   = mem_din_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_done_d  = 1'b0;
        dma_ack_d   = 1'b0;
        rdy_d       = rdy_q;
        arb_en      = 1'b0;
        pend_eff    = cpu_pend_q;
        burst_eff   = burst_cnt_q;
        cyc_eff     = 1'b0;

        case (state_q)
            S_IDLE: arb_en = 1'b1;
            S_CPU_ADR: state_d = S_CPU_DAT;
            S_CPU_DAT: begin
                if (lat_rw_q) cpu_rdata_d = bus.mem_dout;
                cpu_done_d  = 1'b1;
                cpu_pend_d  = 1'b0;
                burst_cnt_d = 8'd0;
                rdy_d       = 1'b1;
                state_d     = S_IDLE;
                // The CPU data phase doubles as the next arbitration slot so a
                // write followed by DMA costs no idle clock.
                arb_en      = 1'b1;
                pend_eff    = 1'b0;
                burst_eff   = 8'd0;
            end
            S_DMA_ADR: state_d = S_DMA_DAT;
            S_DMA_DAT: begin
                // dma_req is still high for the transfer being acked here, so
                // the next grant is decided from IDLE once the requester has seen the ack.
                dma_rdata_d = bus.mem_dout;
                dma_ack_d   = 1'b1;
                if (cpu_pend_q) burst_cnt_d = sat_inc(burst_cnt_q, BURST_MAX);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (arb_en) begin
            cyc_eff = bus.cpu_cyc & ~pend_eff;
            if (pend_eff && (!bus.dma_req || burst_eff == BURST_MAX)) begin
                state_d    = S_CPU_ADR;
                mem_addr_d = lat_addr_q;
                mem_we_d   = ~lat_rw_q;
                mem_din_d  = lat_wdata_q;
            end else if (cyc_eff && (!bus.cpu_rw || !bus.dma_req)) begin
                lat_addr_d  = bus.cpu_addr;
                lat_rw_d    = bus.cpu_rw;
                lat_wdata_d = bus.cpu_wdata;
                state_d     = S_CPU_ADR;
                mem_addr_d  = bus.cpu_addr;
                mem_we_d    = ~bus.cpu_rw;
                mem_din_d   = bus.cpu_wdata;
            end else if (cyc_eff) begin
                lat_addr_d  = bus.cpu_addr;
                lat_rw_d    = bus.cpu_rw;
                lat_wdata_d = bus.cpu_wdata;
                cpu_pend_d  = 1'b1;
                rdy_d       = 1'b0;
                state_d     = S_DMA_ADR;
                mem_addr_d  = bus.dma_addr;
            end else if (bus.dma_req) begin
                state_d    = S_DMA_ADR;
                mem_addr_d = bus.dma_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q     <= S_IDLE;
            cpu_pend_q  <= 1'b0;
            burst_cnt_q <= 8'd0;
            lat_addr_q  <= '0;
            lat_rw_q    <= 1'b0;
            lat_wdata_q <= 8'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_din_q   <= 8'd0;
            cpu_rdata_q <= 8'd0;
            dma_rdata_q <= 8'd0;
            cpu_done_q  <= 1'b0;
            dma_ack_q   <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cpu_pend_q  <= cpu_pend_d;
            burst_cnt_q <= burst_cnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_rw_q    <= lat_rw_d;
            lat_wdata_q <= lat_wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_din_q   <= mem_din_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dma_ack_q   <= dma_ack_d;
            rdy_q       <= rdy_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.rdy       = rdy_q;

endmodule
